int_ctrl: RTL and testbench



---
 rtl/int_ctrl_pkg.sv | 45 ++++
 rtl/int_sync.sv | 28 ++
 rtl/int_ctrl.sv | 97 +++++++++
 tb/tb_int_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared interrupt codes, register offsets and helpers for the machine-level interrupt aggregator.
`ifndef INT_CTRL_DEFINES_SV
`define INT_CTRL_DEFINES_SV
`define INT_BUS      7:0
`define INT_NONE     8'h00
`define INT_TIMER    8'h01
`define INT_UART_REV 8'h02
`endif

package int_ctrl_pkg;

  localparam int unsigned INT_W     = 8;
  localparam int unsigned REG_W     = 32;
  localparam int unsigned MAX_SRC   = 8;

  localparam logic [INT_W-1:0] INT_NONE     = INT_W'(8'h00);
  localparam logic [INT_W-1:0] INT_TIMER    = INT_W'(8'h01);
  localparam logic [INT_W-1:0] INT_UART_REV = INT_W'(8'h02);

  localparam logic [REG_W-1:0] INT_CTRL_BASE = 32'h1000_3000;

  typedef enum logic [1:0] {
    INT_CTRL_ENABLE  = 2'd0,
    INT_CTRL_PENDING = 2'd1,
    INT_CTRL_MODE    = 2'd2,
    INT_CTRL_CLAIM   = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic             we;
    reg_sel_e         sel;
    logic [REG_W-1:0] data;
  } reg_req_t;

  // CLAIM value: bit index + 1 of the one-hot code, 0 when idle.
  function automatic logic [REG_W-1:0] claim_code(input logic [INT_W-1:0] flag);
    logic [REG_W-1:0] c;
    c = '0;
    for (int i = int'(INT_W) - 1; i >= 0; i--) begin
      if (flag[i]) c = REG_W'(i + 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Per-source synchroniser chain followed by a rising-edge detector.
module int_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], src_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt aggregator: synchronise, latch pending, mask, prioritise and expose registers.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [INT_W-1:0]   int_flag_o
);

  logic [NUM_SRC-1:0] level, rise;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] active, clr;
  logic [INT_W-1:0]   flag_d;
  reg_req_t           req;
  logic               unused_bits;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .src_i   (src_i[g]),
      .level_o (level[g]),
      .rise_o  (rise[g])
    );
  end

  assign req.we   = we_i;
  assign req.sel  = reg_sel_e'(addr_i[3:2]);
  assign req.data = data_i;

  // Only the register select and the implemented source bits are meaningful.
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:NUM_SRC]};

  // Register updates, pending latch and fixed-priority selection.
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    clr      = '0;
    flag_d   = INT_NONE;

    if (req.we) begin
      unique case (req.sel)
        INT_CTRL_ENABLE:  enable_d = req.data[NUM_SRC-1:0];
        INT_CTRL_PENDING: clr      = req.data[NUM_SRC-1:0];
        INT_CTRL_MODE:    mode_d   = req.data[NUM_SRC-1:0];
        default:          ;
      endcase
    end

    // Level sources track the line; edge sources set on rise, which beats a same-cycle clear.
    pending_d = (mode_q & level) | (~mode_q & (rise | (pending_q & ~clr)));

    active = pending_q & enable_q;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        flag_d    = INT_NONE;
        flag_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q   <= '0;
      pending_q  <= '0;
      mode_q     <= '0;
      int_flag_o <= INT_NONE;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      mode_q     <= mode_d;
      int_flag_o <= flag_d;
    end
  end

  always_comb begin
    data_o = '0;
    unique case (req.sel)
      INT_CTRL_ENABLE:  data_o = 32'(enable_q);
      INT_CTRL_PENDING: data_o = 32'(pending_q);
      INT_CTRL_MODE:    data_o = 32'(mode_q);
      INT_CTRL_CLAIM:   data_o = claim_code(int_flag_o);
      default:          data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: register vectors plus latency, priority, mask, level and reset sequences.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam logic [1:0] R_EN   = 2'd0;
  localparam logic [1:0] R_PEND = 2'd1;
  localparam logic [1:0] R_MODE = 2'd2;
  localparam logic [1:0] R_CLM  = 2'd3;

  localparam logic [7:0] F_NONE  = 8'h00;
  localparam logic [7:0] F_TIMER = 8'h01;
  localparam logic [7:0] F_UART  = 8'h02;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  int_flag_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic        we;
    logic [1:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  rreg;
    logic [31:0] exp_rd;
    logic [7:0]  exp_flag;
  } vec_t;

  vec_t vecs [7];

  int_ctrl #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_i      (src_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .int_flag_o (int_flag_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] reg_addr(input logic [1:0] r);
    return INT_CTRL_BASE | {28'h0, r, 2'b00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] r, input string name, input logic [31:0] exp);
    addr_i = reg_addr(r);
    #1;
    chk(name, data_o, exp);
  endtask

  task automatic chk_flag(input string name, input logic [7:0] exp);
    chk(name, 32'(int_flag_o), 32'(exp));
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = reg_addr(r);
    data_i = d;
    tick();
    we_i   = 1'b0;
    data_i = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, R_EN,   32'hFFFF_FFFF, R_EN,   32'h0000_00FF, F_NONE};
    vecs[1] = '{1'b1, R_MODE, 32'h1234_56A5, R_MODE, 32'h0000_00A5, F_NONE};
    vecs[2] = '{1'b1, R_MODE, 32'h0000_0000, R_MODE, 32'h0000_0000, F_NONE};
    vecs[3] = '{1'b0, R_EN,   32'h0000_0000, R_CLM,  32'h0000_0000, F_NONE};
    vecs[4] = '{1'b1, R_PEND, 32'hFFFF_FFFF, R_PEND, 32'h0000_0000, F_NONE};
    vecs[5] = '{1'b1, R_CLM,  32'h0000_0005, R_CLM,  32'h0000_0000, F_NONE};
    vecs[6] = '{1'b1, R_EN,   32'h0000_0000, R_EN,   32'h0000_0000, F_NONE};

    src_i  = '0;
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_flag("reset_flag", F_NONE);
    rd(R_EN,   "reset_enable",  32'h0);
    rd(R_PEND, "reset_pending", 32'h0);
    rd(R_MODE, "reset_mode",    32'h0);
    rd(R_CLM,  "reset_claim",   32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      we_i   = vecs[i].we;
      addr_i = reg_addr(vecs[i].wreg);
      data_i = vecs[i].wdata;
      tick();
      we_i   = 1'b0;
      data_i = '0;
      rd(vecs[i].rreg, $sformatf("vec%0d_rd", i), vecs[i].exp_rd);
      chk_flag($sformatf("vec%0d_flag", i), vecs[i].exp_flag);
    end

    // Edge timer: latency k+2 for PENDING, k+3 for the flag, W1C drops it one edge later.
    wr(R_EN, 32'h01);
    src_i = 8'h01;
    tick();
    tick();
    rd(R_PEND, "timer_pend_k1", 32'h0);
    tick();
    rd(R_PEND, "timer_pend_k2", 32'h1);
    chk_flag("timer_flag_k2", F_NONE);
    src_i = 8'h00;
    tick();
    chk_flag("timer_flag_k3", F_TIMER);
    rd(R_CLM, "timer_claim", 32'h1);
    wr(R_PEND, 32'h01);
    chk_flag("timer_flag_clr_edge", F_TIMER);
    rd(R_PEND, "timer_pend_clr", 32'h0);
    tick();
    chk_flag("timer_flag_clr_next", F_NONE);

    // Priority: UART first, then timer takes over; clearing timer falls back to UART.
    wr(R_EN, 32'h03);
    src_i = 8'h02;
    repeat (4) tick();
    chk_flag("prio_uart", F_UART);
    rd(R_CLM, "prio_claim_uart", 32'h2);
    src_i = 8'h03;
    repeat (4) tick();
    chk_flag("prio_timer", F_TIMER);
    rd(R_CLM, "prio_claim_timer", 32'h1);
    rd(R_PEND, "prio_pend", 32'h3);
    wr(R_PEND, 32'h01);
    chk_flag("prio_clr_edge", F_TIMER);
    tick();
    chk_flag("prio_back_uart", F_UART);
    rd(R_CLM, "prio_claim_back", 32'h2);
    src_i = 8'h00;
    wr(R_PEND, 32'h03);
    tick();
    chk_flag("prio_idle", F_NONE);
    rd(R_PEND, "prio_pend_idle", 32'h0);

    // Masking: pending latches while disabled, enabling shows it one edge later.
    wr(R_EN, 32'h00);
    src_i = 8'h02;
    repeat (3) tick();
    src_i = 8'h00;
    rd(R_PEND, "mask_pend", 32'h2);
    chk_flag("mask_flag_off", F_NONE);
    wr(R_EN, 32'h02);
    chk_flag("mask_flag_en_edge", F_NONE);
    tick();
    chk_flag("mask_flag_on", F_UART);
    wr(R_PEND, 32'h02);
    wr(R_EN, 32'h00);
    tick();
    chk_flag("mask_cleanup", F_NONE);

    // Level mode, W1C without effect, level-to-edge switch keeps pending, level drop.
    wr(R_MODE, 32'h02);
    wr(R_EN, 32'h02);
    src_i = 8'h02;
    repeat (3) tick();
    rd(R_PEND, "level_pend", 32'h2);
    wr(R_PEND, 32'h02);
    rd(R_PEND, "level_w1c_ignored", 32'h2);
    chk_flag("level_flag", F_UART);
    wr(R_MODE, 32'h00);
    tick();
    rd(R_PEND, "switch_keep", 32'h2);
    wr(R_PEND, 32'h02);
    tick();
    rd(R_PEND, "switch_no_spurious", 32'h0);
    wr(R_MODE, 32'h02);
    tick();
    rd(R_PEND, "level_again", 32'h2);
    src_i = 8'h00;
    tick();
    tick();
    rd(R_PEND, "level_drop_k1", 32'h2);
    tick();
    rd(R_PEND, "level_drop_k2", 32'h0);
    wr(R_MODE, 32'h00);
    wr(R_EN, 32'h00);
    tick();
    chk_flag("level_cleanup", F_NONE);

    // Set/clear collision: a rise and a W1C on the same edge leaves pending set.
    wr(R_EN, 32'h01);
    src_i = 8'h01;
    repeat (4) tick();
    chk_flag("coll_flag_pre", F_TIMER);
    src_i = 8'h00;
    repeat (3) tick();
    src_i = 8'h01;
    tick();
    tick();
    we_i   = 1'b1;
    addr_i = reg_addr(R_PEND);
    data_i = 32'h01;
    tick();
    we_i   = 1'b0;
    data_i = '0;
    rd(R_PEND, "coll_pend", 32'h1);
    chk_flag("coll_flag_edge", F_TIMER);
    tick();
    chk_flag("coll_flag_next", F_TIMER);

    // Asynchronous reset mid-run with PENDING=0x03.
    wr(R_EN, 32'h03);
    src_i = 8'h03;
    repeat (4) tick();
    rd(R_PEND, "rst_pend_pre", 32'h3);
    chk_flag("rst_flag_pre", F_TIMER);
    #2;
    rst = 1'b1;
    #1;
    chk_flag("rst_flag_async", F_NONE);
    rd(R_PEND, "rst_pend_async", 32'h0);
    src_i = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    rd(R_EN,   "post_rst_enable",  32'h0);
    rd(R_PEND, "post_rst_pending", 32'h0);
    rd(R_MODE, "post_rst_mode",    32'h0);
    rd(R_CLM,  "post_rst_claim",   32'h0);
    chk_flag("post_rst_flag", F_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
